// File: rtl/network_types.sv
// Shared TCP RX types: notification field layout, stream widths and the rx handler FSM encoding.
package network_types;
  localparam int NOTIF_W           = 88;
  localparam int READ_PKG_W        = 32;
  localparam int RX_META_W         = 16;
  localparam int NOTIF_SESSION_LSB = 0;
  localparam int NOTIF_LENGTH_LSB  = 16;
  localparam int NOTIF_IP_LSB      = 32;
  localparam int NOTIF_PORT_LSB    = 64;
  localparam int NOTIF_CLOSED_BIT  = 80;

  typedef enum logic [1:0] {IDLE, REQ, META, DATA} rx_state_t;

  // Only the fields the handler acts on are queued.
  typedef struct packed {
    logic        closed;
    logic [15:0] length;
    logic [15:0] session;
  } notif_entry_t;
endpackage

// File: rtl/tcp_rx_handler_if.sv
// TCP RX handler streams; master is the handler side, slave the environment side.
interface tcp_rx_handler_if #(
  parameter int DATA_WIDTH = 512
);
  import network_types::*;

  logic                    s_axis_notifications_valid;
  logic                    s_axis_notifications_ready;
  logic [NOTIF_W-1:0]      s_axis_notifications_data;
  logic                    m_axis_read_package_valid;
  logic                    m_axis_read_package_ready;
  logic [READ_PKG_W-1:0]   m_axis_read_package_data;
  logic                    s_axis_rx_metadata_valid;
  logic                    s_axis_rx_metadata_ready;
  logic [RX_META_W-1:0]    s_axis_rx_metadata_data;
  logic                    s_axis_rx_data_valid;
  logic                    s_axis_rx_data_ready;
  logic [DATA_WIDTH-1:0]   s_axis_rx_data_data;
  logic [DATA_WIDTH/8-1:0] s_axis_rx_data_keep;
  logic                    s_axis_rx_data_last;

  modport master (
    input  s_axis_notifications_valid, s_axis_notifications_data,
    output s_axis_notifications_ready,
    output m_axis_read_package_valid, m_axis_read_package_data,
    input  m_axis_read_package_ready,
    input  s_axis_rx_metadata_valid, s_axis_rx_metadata_data,
    output s_axis_rx_metadata_ready,
    input  s_axis_rx_data_valid, s_axis_rx_data_data, s_axis_rx_data_keep, s_axis_rx_data_last,
    output s_axis_rx_data_ready
  );

  modport slave (
    output s_axis_notifications_valid, s_axis_notifications_data,
    input  s_axis_notifications_ready,
    input  m_axis_read_package_valid, m_axis_read_package_data,
    output m_axis_read_package_ready,
    output s_axis_rx_metadata_valid, s_axis_rx_metadata_data,
    input  s_axis_rx_metadata_ready,
    output s_axis_rx_data_valid, s_axis_rx_data_data, s_axis_rx_data_keep, s_axis_rx_data_last,
    input  s_axis_rx_data_ready
  );
endinterface

// File: rtl/tcp_notif_fifo.sv
// Synchronous notification queue, head visible combinationally; one cycle from push to visible head.
// Backpressure via full; a push while full is refused even if a pop happens in the same cycle.
module tcp_notif_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/tcp_rx_handler.sv
// TCP RX handler: queues notifications, issues read requests, consumes metadata and payload; notification to request in 2 cycles.
// Notifications backpressured only when the queue is full; statistics built only with RX_HANDLER_STATS_EN.
module tcp_rx_handler
  import network_types::*;
#(
  parameter int NOTIF_FIFO_DEPTH = 8,
  parameter int DATA_WIDTH       = 512
) (
  input  logic               aclk,
  input  logic               aresetn,
  tcp_rx_handler_if.master   bus,
  output logic [63:0]        rx_byte_cnt,
  output logic [31:0]        rx_pkt_cnt,
  output logic [31:0]        close_cnt,
  output logic               err_len
);
  logic [1:0]   rst_sync;
  logic         rst_n;
  rx_state_t    state;
  rx_state_t    state_nxt;
  notif_entry_t push_entry;
  notif_entry_t head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         notif_rdy;
  logic         head_skip;
  logic         rd_vld;
  logic         meta_rdy;
  logic         data_rdy;
  logic [15:0]  req_session;
  logic [15:0]  req_length;
  logic         unused_fields;
  logic         unused_payload;

  // Assert asynchronously, release two aclk edges later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign push_entry.closed  = bus.s_axis_notifications_data[NOTIF_CLOSED_BIT];
  assign push_entry.length  = bus.s_axis_notifications_data[NOTIF_LENGTH_LSB +: 16];
  assign push_entry.session = bus.s_axis_notifications_data[NOTIF_SESSION_LSB +: 16];
  assign unused_fields = ^{bus.s_axis_notifications_data[NOTIF_W-1:NOTIF_CLOSED_BIT+1],
                           bus.s_axis_notifications_data[NOTIF_PORT_LSB +: 16],
                           bus.s_axis_notifications_data[NOTIF_IP_LSB +: 32]};

  assign notif_rdy = rst_n && !fifo_full;

  tcp_notif_fifo #(
    .DEPTH (NOTIF_FIFO_DEPTH),
    .WIDTH ($bits(notif_entry_t))
  ) u_notif_fifo (
    .aclk     (aclk),
    .aresetn  (rst_n),
    .push     (bus.s_axis_notifications_valid && notif_rdy),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Closed or empty sessions are retired straight from IDLE without a read request.
  assign head_skip = head.closed || (head.length == 16'd0);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_session <= '0;
      req_length  <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_pop && !head_skip) begin
        req_session <= head.session;
        req_length  <= head.length;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    rd_vld    = 1'b0;
    meta_rdy  = 1'b0;
    data_rdy  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!head_skip) state_nxt = REQ;
        end
      end
      REQ: begin
        rd_vld = 1'b1;
        if (bus.m_axis_read_package_ready) state_nxt = META;
      end
      META: begin
        meta_rdy = 1'b1;
        if (bus.s_axis_rx_metadata_valid) state_nxt = DATA;
      end
      DATA: begin
        data_rdy = 1'b1;
        if (bus.s_axis_rx_data_valid && bus.s_axis_rx_data_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.s_axis_notifications_ready = notif_rdy;
  assign bus.m_axis_read_package_valid  = rd_vld;
  assign bus.m_axis_read_package_data   = {req_length, req_session};
  assign bus.s_axis_rx_metadata_ready   = meta_rdy;
  assign bus.s_axis_rx_data_ready       = data_rdy;

`ifdef RX_HANDLER_STATS_EN
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int BEAT_W = $clog2(KEEP_W) + 1;

  logic [BEAT_W-1:0] beat_bytes;
  logic [15:0]       pkt_bytes;
  logic [15:0]       pkt_sum;
  logic              meta_fire;
  logic              data_fire;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++)
      beat_bytes = beat_bytes + BEAT_W'(bus.s_axis_rx_data_keep[i]);
  end

  assign pkt_sum   = pkt_bytes + 16'(beat_bytes);
  assign meta_fire = meta_rdy && bus.s_axis_rx_metadata_valid;
  assign data_fire = data_rdy && bus.s_axis_rx_data_valid;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_bytes   <= '0;
      rx_byte_cnt <= '0;
      rx_pkt_cnt  <= '0;
      close_cnt   <= '0;
      err_len     <= 1'b0;
    end else begin
      if (fifo_pop && head.closed) close_cnt <= close_cnt + 32'd1;
      if (meta_fire && (bus.s_axis_rx_metadata_data != req_session)) err_len <= 1'b1;
      if (data_fire) begin
        rx_byte_cnt <= rx_byte_cnt + 64'(beat_bytes);
        if (bus.s_axis_rx_data_last) begin
          rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
          pkt_bytes  <= '0;
          if (pkt_sum != req_length) err_len <= 1'b1;
        end else begin
          pkt_bytes <= pkt_sum;
        end
      end
    end
  end

  assign unused_payload = ^bus.s_axis_rx_data_data[DATA_WIDTH-1:0];
`else
  assign rx_byte_cnt    = '0;
  assign rx_pkt_cnt     = '0;
  assign close_cnt      = '0;
  assign err_len        = 1'b0;
  assign unused_payload = ^{bus.s_axis_rx_data_data[DATA_WIDTH-1:0],
                            bus.s_axis_rx_data_keep[DATA_WIDTH/8-1:0],
                            bus.s_axis_rx_metadata_data};
`endif
endmodule

// File: doc/tcp_rx_handler.md
TCP_RX_HANDLER -- requirements
Module: tcp_rx_handler

Interface
REQ-001 Parameter NOTIF_FIFO_DEPTH, default 8, is the pending-notification queue depth (power of two, 2..64).
REQ-002 Parameter DATA_WIDTH, default 512, is the rx data beat width; KEEP width SHALL be DATA_WIDTH/8.
REQ-003 aclk  in  1  sole clock, rising edge; aresetn  in  1  asynchronous active-low reset.
REQ-004 s_axis_notifications_valid/ready/data  in/out/in  1/1/88  notification: [15:0] session, [31:16] length, [63:32] ip, [79:64] port, [80] closed.
REQ-005 m_axis_read_package_valid/ready/data  out/in/out  1/1/32  read request: [15:0] session, [31:16] length.
REQ-006 s_axis_rx_metadata_valid/ready/data  in/out/in  1/1/16  session of the following data.
REQ-007 s_axis_rx_data_valid/ready/data/keep/last  in/out/in/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8/1  payload beats.
REQ-008 rx_byte_cnt  out  64; rx_pkt_cnt  out  32; close_cnt  out  32; err_len  out  1  sticky length mismatch.

Function
REQ-009 Each accepted notification SHALL be pushed into a FIFO; s_axis_notifications_ready SHALL be low only when the FIFO is full.
REQ-010 FSM states: IDLE, REQ, META, DATA.
REQ-011 IDLE: FIFO non-empty with closed=1 or length=0 -> pop, increment close_cnt if closed=1, stay IDLE; otherwise pop the head and go to REQ.
REQ-012 REQ: m_axis_read_package_valid SHALL be high with session/length of the popped entry and held stable until ready; on handshake -> META.
REQ-013 META: s_axis_rx_metadata_ready high; on handshake -> DATA; a session differing from the request SHALL set err_len.
REQ-014 DATA: s_axis_rx_data_ready high; each beat adds popcount(keep) to a 16-bit per-packet byte accumulator and to rx_byte_cnt; on the last beat -> IDLE, increment rx_pkt_cnt.
REQ-015 At last-beat, if the accumulated bytes (including that beat) do not equal the requested length, err_len SHALL be set.
REQ-016 Ready outputs SHALL be low in every state other than the one named above.
REQ-017 Minimum latency: notification accepted in cycle N -> read_package_valid in cycle N+2 (one cycle FIFO write, one cycle pop to REQ).
REQ-018 A notification push and a pop in the same cycle with the FIFO full SHALL be refused (ready reflects full before the pop).
REQ-019 Counters SHALL wrap modulo 2^width without saturation or flag.
REQ-020 Back-to-back packets: IDLE -> REQ SHALL cost one cycle; no other bubbles.

Reset
REQ-021 On aresetn low, the FSM SHALL enter IDLE, the FIFO SHALL empty, all valid/ready outputs SHALL be 0, all counters and err_len SHALL be 0, read_package data SHALL be 0.
REQ-022 Reset asserted mid-packet SHALL abandon the packet without recording it; the first beat after release is treated as a new notification cycle.
REQ-023 Reset deassertion SHALL be synchronised to aclk internally before affecting the FSM.

Configuration
REQ-024 Macro RX_HANDLER_STATS_EN: when defined, rx_byte_cnt, rx_pkt_cnt, close_cnt and err_len SHALL operate as specified; when undefined, those outputs SHALL be constant 0 and their logic absent; handshake behaviour identical in both cases.

Structure
REQ-025 Notification bit-field offsets, the 88/32/16 meta widths and the FSM state enum SHALL live in the shared network_types package.
REQ-026 The notification queue SHALL be a sub-module tcp_notif_fifo (synchronous FIFO, full/empty, parameterised depth and width).

Verification
REQ-027 Notification session 5, length 128 -> read_package {5,128}; metadata 5; 2 full-keep beats -> rx_pkt_cnt=1, rx_byte_cnt=128, err_len=0.
REQ-028 Notification length 100, beats keep all-ones then 36 low bits set with last -> rx_byte_cnt=100, err_len=0; same with 40 bits set -> err_len=1.
REQ-029 Notification closed=1 session 3 -> no read_package, close_cnt=1, FSM returns to IDLE next cycle.
REQ-030 Push 9 notifications with read_package_ready held low, depth 8 -> notifications_ready low after the 8th FIFO entry (one held in REQ), no loss after release; 9 packets completed in order.
REQ-031 Assert aresetn low during DATA beat 2 of 4 -> all outputs 0; after release, new notification session 7 completes normally with rx_pkt_cnt=1.
REQ-032 Build without RX_HANDLER_STATS_EN, repeat REQ-027 -> identical handshakes, all counters read 0.
